// File: rtl/alu_arbiter_if.sv
// Requester/ALU/response bundle between the shared-ALU arbiter and its clients.
// slave = arbiter side, master = requester/ALU side.
interface alu_arbiter_if #(
  parameter int DW  = 8,
  parameter int OPW = 4
);
  logic [1:0]     req;
  logic [OPW-1:0] req_op0;
  logic [DW-1:0]  req_a0;
  logic [DW-1:0]  req_b0;
  logic [OPW-1:0] req_op1;
  logic [DW-1:0]  req_a1;
  logic [DW-1:0]  req_b1;
  logic [1:0]     gnt;
  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [DW-1:0]  alu_out;
  logic           alu_zero;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  logic [DW-1:0]  rsp_data;
  logic           rsp_zero;
  logic           busy;

  modport slave (
    input  req, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1,
    input  alu_out, alu_zero, rsp_ready,
    output gnt, alu_op, alu_a, alu_b, rsp_valid, rsp_data, rsp_zero, busy
  );

  modport master (
    output req, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1,
    output alu_out, alu_zero, rsp_ready,
    input  gnt, alu_op, alu_a, alu_b, rsp_valid, rsp_data, rsp_zero, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter for one shared combinational ALU with registered issue and response.
// Define ALU_ARB_RR_EN for round-robin on contention; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int DW  = 8,
  parameter int OPW = 4
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  state_t         state_r, state_next;
  logic [1:0]     gnt_r, gnt_next;
  logic [OPW-1:0] op_r, op_next;
  logic [DW-1:0]  a_r, a_next;
  logic [DW-1:0]  b_r, b_next;
  logic [1:0]     rsp_valid_r, rsp_valid_next;
  logic [DW-1:0]  rsp_data_r, rsp_data_next;
  logic           rsp_zero_r, rsp_zero_next;
  logic           busy_r, busy_next;
  logic           id_r, id_next;
  logic           last_r, last_next;
  logic           win;
  logic           grant;

  // Winner selection; only meaningful when some request is present.
  always_comb begin
    win = 1'b0;
`ifdef ALU_ARB_RR_EN
    if (bus.req == 2'b11) begin
      win = ~last_r;
    end else begin
      win = bus.req[1];
    end
`else
    if (bus.req[0]) begin
      win = 1'b0;
    end else begin
      win = bus.req[1];
    end
`endif
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next     = state_r;
    gnt_next       = 2'b00;
    op_next        = op_r;
    a_next         = a_r;
    b_next         = b_r;
    rsp_valid_next = rsp_valid_r;
    rsp_data_next  = rsp_data_r;
    rsp_zero_next  = rsp_zero_r;
    id_next        = id_r;
    last_next      = last_r;
    grant          = 1'b0;

    case (state_r)
      IDLE: begin
        if (bus.req != 2'b00) begin
          grant = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE: begin
        rsp_data_next  = bus.alu_out;
        rsp_zero_next  = bus.alu_zero;
        rsp_valid_next = id_r ? 2'b10 : 2'b01;
        state_next     = RESP;
      end
      RESP: begin
        // Only the owner's ready completes the handshake.
        if (bus.rsp_ready[id_r]) begin
          rsp_valid_next = 2'b00;
          if (bus.req != 2'b00) begin
            grant = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          state_next = RESP;
        end
      end
      default: begin
        state_next     = IDLE;
        rsp_valid_next = 2'b00;
      end
    endcase

    if (grant) begin
      state_next = ISSUE;
      id_next    = win;
      last_next  = win;
      gnt_next   = win ? 2'b10 : 2'b01;
      op_next    = win ? bus.req_op1 : bus.req_op0;
      a_next     = win ? bus.req_a1  : bus.req_a0;
      b_next     = win ? bus.req_b1  : bus.req_b0;
    end else begin
      gnt_next = 2'b00;
    end

    busy_next = (state_next != IDLE);
  end

  // State and output registers; async reset drops any in-flight op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      gnt_r       <= 2'b00;
      op_r        <= '0;
      a_r         <= '0;
      b_r         <= '0;
      rsp_valid_r <= 2'b00;
      rsp_data_r  <= '0;
      rsp_zero_r  <= 1'b0;
      busy_r      <= 1'b0;
      id_r        <= 1'b0;
      last_r      <= 1'b1;
    end else begin
      state_r     <= state_next;
      gnt_r       <= gnt_next;
      op_r        <= op_next;
      a_r         <= a_next;
      b_r         <= b_next;
      rsp_valid_r <= rsp_valid_next;
      rsp_data_r  <= rsp_data_next;
      rsp_zero_r  <= rsp_zero_next;
      busy_r      <= busy_next;
      id_r        <= id_next;
      last_r      <= last_next;
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.alu_op    = op_r;
  assign bus.alu_a     = a_r;
  assign bus.alu_b     = b_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.rsp_zero  = rsp_zero_r;
  assign bus.busy      = busy_r;
endmodule
